// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: sequencer FSM encoding, register-zero constant
// and the bit offsets of the branch/jump fields inside the exe2mem bundle.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } fsm_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int EXMEM_ZERO_BIT = 0;
  localparam int EXMEM_BEQ_BIT  = 1;
  localparam int EXMEM_JUMP_BIT = 2;
  localparam int EXMEM_CTRL_W   = 3;

  // Taken branch (BranchEq with zero set) or unconditional jump.
  function automatic logic is_redirect(input logic [EXMEM_CTRL_W-1:0] ctrl);
    return (ctrl[EXMEM_BEQ_BIT] & ctrl[EXMEM_ZERO_BIT]) | ctrl[EXMEM_JUMP_BIT];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clr)
      count <= '0;
    else if (inc && (count != {CNT_W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, MEM-stage redirects and data-memory
// waits with a timeout into a sticky HALT, plus stall/redirect statistics.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_to_reg,
  input  logic [4:0]       ex_write_reg,
  input  logic             mem_branch_eq,
  input  logic             mem_zero,
  input  logic             mem_jump,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

  fsm_state_e                state;
  logic [7:0]                wait_cnt;
  logic [EXMEM_CTRL_W-1:0]   exmem_ctrl;
  logic                      redirect;
  logic                      load_use;
  logic                      mem_wait;
  logic                      freeze;
  logic                      take_redirect;

  always_comb begin
    exmem_ctrl                 = '0;
    exmem_ctrl[EXMEM_ZERO_BIT] = mem_zero;
    exmem_ctrl[EXMEM_BEQ_BIT]  = mem_branch_eq;
    exmem_ctrl[EXMEM_JUMP_BIT] = mem_jump;
  end

  assign redirect = is_redirect(exmem_ctrl);
  assign load_use = ex_mem_to_reg && (ex_write_reg != REG_ZERO) &&
                    ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));
  // Deasserting mem_access while waiting counts as completion.
  assign mem_wait = mem_access && !dmem_ready;

  // In MEM_WAIT an unfinished access keeps the freeze; a finished one falls
  // through to normal RUN priorities, so a pending redirect goes on release.
  always_comb begin
    pc_en         = 1'b1;
    pc_sel        = 1'b0;
    ifid_en       = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_en      = 1'b1;
    exmem_flush   = 1'b0;
    memwb_flush   = 1'b0;
    freeze        = 1'b0;
    take_redirect = 1'b0;
    if (clr) begin
      if (state == ST_HALT || mem_wait) begin
        freeze = 1'b1;
      end else if (redirect) begin
        take_redirect = 1'b1;
        pc_sel        = 1'b1;
        ifid_flush    = 1'b1;
        idex_flush    = 1'b1;
        exmem_flush   = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
    if (freeze) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      halted   <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_wait) begin
            if (TIMEOUT_LIM <= 9'd1) begin
              state    <= ST_HALT;
              halted   <= 1'b1;
              wait_cnt <= '0;
            end else begin
              state    <= ST_MEM_WAIT;
              wait_cnt <= 8'd1;
            end
          end
        end
        ST_MEM_WAIT: begin
          if (!mem_wait) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (({1'b0, wait_cnt} + 9'd1) >= TIMEOUT_LIM) begin
            state    <= ST_HALT;
            halted   <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (clr),
    .inc   (!pc_en),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (clr),
    .inc   (take_redirect),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed hazard scenarios followed by
// randomized traffic, checked against a cycle-level reference model.
module tb_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int MAXC        = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             clr;
  logic [4:0]       id_rs, id_rt, ex_write_reg;
  logic             id_uses_rt, ex_mem_to_reg;
  logic             mem_branch_eq, mem_zero, mem_jump, mem_access, dmem_ready;
  logic             pc_en, pc_sel, ifid_en, ifid_flush, idex_flush;
  logic             exmem_en, exmem_flush, memwb_flush, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .clr           (clr),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_write_reg  (ex_write_reg),
    .mem_branch_eq (mem_branch_eq),
    .mem_zero      (mem_zero),
    .mem_jump      (mem_jump),
    .mem_access    (mem_access),
    .dmem_ready    (dmem_ready),
    .pc_en         (pc_en),
    .pc_sel        (pc_sel),
    .ifid_en       (ifid_en),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .exmem_en      (exmem_en),
    .exmem_flush   (exmem_flush),
    .memwb_flush   (memwb_flush),
    .halted        (halted),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic pc_en, pc_sel, ifid_en, ifid_flush, idex_flush;
    logic exmem_en, exmem_flush, memwb_flush, halted;
    int   stall, flush;
  } exp_t;

  exp_t sbq[$];
  int   assertCount = 0;
  int   failCount   = 0;

  // Reference model: consecutive stuck-memory cycles, sticky halt, counters.
  int   mStuck = 0;
  bit   mHalt  = 0;
  int   mStall = 0;
  int   mFlush = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit c, input logic [4:0] rs, input logic [4:0] rt,
                               input bit urt, input bit mtr, input logic [4:0] wr,
                               input bit beq, input bit z, input bit j,
                               input bit acc, input bit rdy);
    exp_t e;
    bit   redirect, loadUse, stuck;
    @(posedge clk);
    #1;
    clr = c; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_to_reg = mtr;
    ex_write_reg = wr; mem_branch_eq = beq; mem_zero = z; mem_jump = j;
    mem_access = acc; dmem_ready = rdy;

    e.pc_en = 1; e.pc_sel = 0; e.ifid_en = 1; e.ifid_flush = 0; e.idex_flush = 0;
    e.exmem_en = 1; e.exmem_flush = 0; e.memwb_flush = 0;
    e.halted = mHalt; e.stall = mStall; e.flush = mFlush;

    if (c) begin
      redirect = (beq && z) || j;
      loadUse  = mtr && (wr != 0) && ((wr == rs) || (urt && (wr == rt)));
      stuck    = acc && !rdy;
      if (mHalt || stuck) begin
        e.pc_en = 0; e.ifid_en = 0; e.exmem_en = 0; e.memwb_flush = 1;
      end else if (redirect) begin
        e.pc_sel = 1; e.ifid_flush = 1; e.idex_flush = 1; e.exmem_flush = 1;
      end else if (loadUse) begin
        e.pc_en = 0; e.ifid_en = 0; e.idex_flush = 1;
      end
      if (!mHalt) begin
        if (stuck) begin
          mStuck++;
          if (mStuck >= MEM_TIMEOUT) begin
            mHalt  = 1;
            mStuck = 0;
          end
        end else begin
          mStuck = 0;
        end
      end
      if (!e.pc_en && mStall < MAXC) mStall++;
      if (e.pc_sel && mFlush < MAXC) mFlush++;
    end else begin
      mStuck = 0; mHalt = 0; mStall = 0; mFlush = 0;
    end
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 0, 0, 0);
  endtask

  task automatic randCycle(input int stuckPct, input int clrLowPct);
    bit c, acc, rdy;
    c   = ($urandom_range(0, 99) >= clrLowPct);
    acc = ($urandom_range(0, 99) < 40);
    rdy = ($urandom_range(0, 99) >= stuckPct);
    applyStimulus(c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 50),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 99) < 30),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 10), acc, rdy);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checkOutput("pc_en",       32'(pc_en),       32'(e.pc_en));
      checkOutput("pc_sel",      32'(pc_sel),      32'(e.pc_sel));
      checkOutput("ifid_en",     32'(ifid_en),     32'(e.ifid_en));
      checkOutput("ifid_flush",  32'(ifid_flush),  32'(e.ifid_flush));
      checkOutput("idex_flush",  32'(idex_flush),  32'(e.idex_flush));
      checkOutput("exmem_en",    32'(exmem_en),    32'(e.exmem_en));
      checkOutput("exmem_flush", 32'(exmem_flush), 32'(e.exmem_flush));
      checkOutput("memwb_flush", 32'(memwb_flush), 32'(e.memwb_flush));
      checkOutput("halted",      32'(halted),      32'(e.halted));
      checkOutput("stall_cnt",   32'(stall_cnt),   32'(e.stall));
      checkOutput("flush_cnt",   32'(flush_cnt),   32'(e.flush));
    end
  end

  initial begin
    clr = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_mem_to_reg = 0; ex_write_reg = 0;
    mem_branch_eq = 0; mem_zero = 0; mem_jump = 0; mem_access = 0; dmem_ready = 0;
    repeat (2) @(posedge clk);
    $display("[TB] reset released, directed scenarios");

    // reset-state outputs with hazards present on the inputs
    applyStimulus(0, 5'd8, 5'd0, 0, 1, 5'd8, 1, 1, 1, 1, 0);
    idle(2);

    // load-use on rs: one bubble
    applyStimulus(1, 5'd8, 5'd3, 1, 1, 5'd8, 0, 0, 0, 0, 0);
    idle(2);
    // load to r0 never stalls; rt match ignored when rt not a source
    applyStimulus(1, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0, 0, 0);
    applyStimulus(1, 5'd3, 5'd8, 0, 1, 5'd8, 0, 0, 0, 0, 0);
    applyStimulus(1, 5'd3, 5'd8, 1, 1, 5'd8, 0, 0, 0, 0, 0);
    idle(1);

    // taken branch squashes a simultaneous load-use; untaken does nothing
    applyStimulus(1, 5'd8, 5'd3, 1, 1, 5'd8, 1, 1, 0, 0, 0);
    applyStimulus(1, 5'd1, 5'd2, 1, 0, 5'd0, 1, 0, 0, 0, 0);
    idle(1);

    // three stuck cycles, then release together with a jump
    for (int i = 0; i < 3; i++) applyStimulus(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 1, 1, 0);
    applyStimulus(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 1, 1, 1);
    idle(2);

    // access withdrawn mid-wait counts as ready
    applyStimulus(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 0, 1, 0);
    applyStimulus(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 0, 0, 0);
    idle(1);

    // timeout into halt, frozen with ready back, then a single reset edge
    applyStimulus(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 0, 1, 0);
    applyStimulus(1, 5'd1, 5'd2, 1, 0, 5'd0, 1, 1, 1, 1, 1);
    applyStimulus(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 0, 0, 0);
    idle(2);

    // stall counter saturation under held load-use
    for (int i = 0; i < 20; i++) applyStimulus(1, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0, 0, 0);
    idle(1);

    $display("[TB] randomized phase");
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 1500; i++) randCycle(40, 1);
    for (int i = 0; i < 800; i++)  randCycle(85, 3);
    for (int i = 0; i < 500; i++)  randCycle(20, 2);

    repeat (2) @(posedge clk);
    checkOutput("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
